// File: rtl/wb_regfile.sv
// Writeback-stage register file: 15 x 64-bit registers, two combinational read
// ports, processor status, sticky halt and a retired-instruction counter.
module wb_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  W_stat,
    input  logic [3:0]  W_icode,
    input  logic [63:0] W_valE,
    input  logic [63:0] W_valM,
    input  logic [3:0]  W_dstE,
    input  logic [3:0]  W_dstM,
    input  logic        W_stall,
    input  logic [3:0]  srcA,
    input  logic [3:0]  srcB,
    output logic [63:0] d_rvalA,
    output logic [63:0] d_rvalB,
    output logic [2:0]  Stat,
    output logic        halted,
    output logic [63:0] retired_count
);

    localparam logic [2:0] STAT_AOK  = 3'd1;
    localparam logic [3:0] ICODE_NOP = 4'h1;
    localparam logic [3:0] RNONE     = 4'hF;

    logic [63:0] regs [0:14];
    logic        commit;

    assign commit = !W_stall && !halted;

    // The M-port write is issued after the E-port write, so it wins when both
    // target the same register in one commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) begin
                regs[i] <= '0;
            end
            Stat          <= STAT_AOK;
            halted        <= 1'b0;
            retired_count <= '0;
        end else if (commit) begin
            if (W_stat == STAT_AOK) begin
                if (W_dstE != RNONE) begin
                    regs[W_dstE] <= W_valE;
                end
                if (W_dstM != RNONE) begin
                    regs[W_dstM] <= W_valM;
                end
                Stat <= STAT_AOK;
            end else begin
                Stat   <= W_stat;
                halted <= 1'b1;
            end
            if (W_icode != ICODE_NOP) begin
                retired_count <= retired_count + 64'd1;
            end
        end
    end

    assign d_rvalA = (srcA == RNONE) ? 64'h0 : regs[srcA];
    assign d_rvalB = (srcB == RNONE) ? 64'h0 : regs[srcB];

endmodule

// File: tb/tb_wb_regfile.sv
// Directed scenarios followed by random traffic, checked against an
// array-based reference model of the register file.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  W_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic [3:0]  W_dstE;
    logic [3:0]  W_dstM;
    logic        W_stall;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [63:0] d_rvalA;
    logic [63:0] d_rvalB;
    logic [2:0]  Stat;
    logic        halted;
    logic [63:0] retired_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] m_reg [16];
    logic [2:0]  m_stat;
    logic        m_halt;
    logic [63:0] m_cnt;

    wb_regfile dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .W_stat        (W_stat),
        .W_icode       (W_icode),
        .W_valE        (W_valE),
        .W_valM        (W_valM),
        .W_dstE        (W_dstE),
        .W_dstM        (W_dstM),
        .W_stall       (W_stall),
        .srcA          (srcA),
        .srcB          (srcB),
        .d_rvalA       (d_rvalA),
        .d_rvalB       (d_rvalB),
        .Stat          (Stat),
        .halted        (halted),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: what one rising edge does with the current inputs.
    task automatic model_edge();
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) m_reg[i] = 64'h0;
            m_stat = 3'd1;
            m_halt = 1'b0;
            m_cnt  = 64'h0;
        end else if (!W_stall && !m_halt) begin
            if (W_stat == 3'd1) begin
                if (W_dstE != 4'hF) m_reg[W_dstE] = W_valE;
                if (W_dstM != 4'hF) m_reg[W_dstM] = W_valM;
            end else begin
                m_halt = 1'b1;
            end
            m_stat = W_stat;
            if (W_icode != 4'h1) m_cnt = m_cnt + 64'd1;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("Stat", 64'(Stat), 64'(m_stat));
        check("halted", 64'(halted), 64'(m_halt));
        check("retired_count", retired_count, m_cnt);
        check("d_rvalA", d_rvalA, (srcA == 4'hF) ? 64'h0 : m_reg[srcA]);
        check("d_rvalB", d_rvalB, (srcB == 4'hF) ? 64'h0 : m_reg[srcB]);
    endtask

    task automatic drive(input logic rst, input logic stall, input logic [2:0] st,
                         input logic [3:0] ic, input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm,
                         input logic [3:0] sa, input logic [3:0] sb);
        rst_n   = rst;
        W_stall = stall;
        W_stat  = st;
        W_icode = ic;
        W_dstE  = de;
        W_valE  = ve;
        W_dstM  = dm;
        W_valM  = vm;
        srcA    = sa;
        srcB    = sb;
        cycle();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_reg[i] = 64'h0;
        m_stat = 3'd1;
        m_halt = 1'b0;
        m_cnt  = 64'h0;

        drive(0, 0, 3'd1, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0, 4'h0, 4'h1);
        check("reset_stat", 64'(Stat), 64'd1);
        check("reset_halted", 64'(halted), 64'd0);
        check("reset_count", retired_count, 64'd0);

        drive(1, 0, 3'd1, 4'h3, 4'h0, 64'h0A, 4'hF, 64'h0, 4'h0, 4'hF);
        check("aok_write_r0", d_rvalA, 64'h0A);
        check("aok_count", retired_count, 64'd1);

        drive(1, 0, 3'd1, 4'hB, 4'h4, 64'h100, 4'h4, 64'h55, 4'h0, 4'h4);
        check("m_priority_r4", d_rvalB, 64'h55);
        check("m_priority_count", retired_count, 64'd2);

        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 3'd1, 4'h3, 4'h2, 64'hFF, 4'hF, 64'h0, 4'h2, 4'h0);
            check("stall_r2", d_rvalA, 64'h0);
            check("stall_count", retired_count, 64'd2);
        end
        drive(1, 0, 3'd1, 4'h3, 4'h2, 64'hFF, 4'hF, 64'h0, 4'h2, 4'h0);
        check("unstall_r2", d_rvalA, 64'hFF);
        check("unstall_count", retired_count, 64'd3);

        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 3'd1, 4'h1, 4'hF, 64'h0, 4'hF, 64'h0, 4'hF, 4'hF);
            check("bubble_rdA", d_rvalA, 64'h0);
            check("bubble_count", retired_count, 64'd3);
        end

        drive(1, 0, 3'd3, 4'h5, 4'hF, 64'h0, 4'h3, 64'h77, 4'h3, 4'h0);
        check("adr_r3", d_rvalA, 64'h0);
        check("adr_stat", 64'(Stat), 64'd3);
        check("adr_halted", 64'(halted), 64'd1);
        check("adr_count", retired_count, 64'd4);
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 3'd1, 4'h2, 4'h3, 64'h99, 4'h3, 64'h88, 4'h3, 4'h0);
            check("halted_r3", d_rvalA, 64'h0);
            check("halted_r0", d_rvalB, 64'h0A);
            check("halted_stat", 64'(Stat), 64'd3);
            check("halted_count", retired_count, 64'd4);
        end

        drive(0, 1, 3'd1, 4'h3, 4'h0, 64'h1, 4'hF, 64'h0, 4'h0, 4'h4);
        check("rst_r0", d_rvalA, 64'h0);
        check("rst_r4", d_rvalB, 64'h0);
        check("rst_stat", 64'(Stat), 64'd1);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_count", retired_count, 64'd0);

        for (int k = 0; k < 600; k++) begin
            logic        r;
            logic        s;
            logic [2:0]  st;
            r  = ($urandom_range(0, 99) >= 2);
            s  = ($urandom_range(0, 99) < 25);
            st = ($urandom_range(0, 99) < 3) ? 3'($urandom_range(2, 4)) : 3'd1;
            drive(r, s, st, 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), {$urandom, $urandom},
                  4'($urandom_range(0, 15)), {$urandom, $urandom},
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
